// File: rtl/uart_tx_multi_pkg.sv
// Shared encodings for the multi-width UART transmitter: parity modes, framing states
// and the parity helper used when a word is loaded into the shift register.
package uart_tx_multi_pkg;

  localparam int MAX_DATA_W = 8;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_MARK = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  // Narrow words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input par_mode_e mode);
    logic par;
    case (mode)
      PAR_ODD:  par = ~(^data);
      PAR_EVEN: par = ^data;
      PAR_MARK: par = 1'b1;
      default:  par = 1'b0;
    endcase
    return par;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through TX FIFO with registered full/empty/level status.
module uart_tx_fifo
  import uart_tx_multi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  count_q;
  logic [LVL_W-1:0]  count_d;
  logic              full_q;
  logic              empty_q;
  logic              wr_ok_s;
  logic              rd_ok_s;

  // A pop in the same cycle never makes room for a write arriving while full.
  assign wr_ok_s = wr_en_i & ~full_q;
  assign rd_ok_s = rd_en_i & ~empty_q;

  always_comb begin
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= LVL_W'(0);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == LVL_W'(DEPTH));
      empty_q <= (count_d == LVL_W'(0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = count_q;

endmodule

// File: rtl/uart_tx_multi.sv
// UART transmitter: TX FIFO feeding a tick-paced framing FSM (start, 5..8 data bits,
// optional parity, 1 or 2 stop bits) with back-to-back frames and FIFO status outputs.
module uart_tx_multi
  import uart_tx_multi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              bps_tick,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              TXD,
  output logic              bps_en,
  output logic              busy,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow
);

  localparam int              CNT_W    = $clog2(MAX_DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  par_mode_e         par_mode_q, par_mode_d;
  logic              stop2_q, stop2_d;
  logic              par_bit_q, par_bit_d;
  logic              stop_wait_q, stop_wait_d;
  logic              txd_q, txd_d;
  logic              busy_q;
  logic              overflow_q;
  logic              pop_s;
  logic              in_stop_s;
  logic              frame_end_s;
  logic [DATA_W-1:0] fifo_rd_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [LVL_W-1:0]  fifo_level_s;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (RSTn),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (pop_s),
    .rd_data_o (fifo_rd_data_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .level_o   (fifo_level_s)
  );

  // stop_wait_q marks that the final stop bit is on the line and the next tick closes the frame.
  assign in_stop_s   = (state_q == ST_STOP1) | (state_q == ST_STOP2);
  assign frame_end_s = bps_tick & stop_wait_q & in_stop_s;
  assign pop_s       = ~fifo_empty_s & ((state_q == ST_IDLE) | frame_end_s);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      shift_q     <= {DATA_W{1'b0}};
      bit_cnt_q   <= CNT_W'(0);
      par_mode_q  <= PAR_NONE;
      stop2_q     <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_wait_q <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_mode_q  <= par_mode_d;
      stop2_q     <= stop2_d;
      par_bit_q   <= par_bit_d;
      stop_wait_q <= stop_wait_d;
      txd_q       <= txd_d;
      busy_q      <= (state_d != ST_IDLE);
      overflow_q  <= wr_en & fifo_full_s;
    end
  end

  // The closing stop tick doubles as the start-bit tick of a queued frame, so it goes straight to DATA.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) state_d = ST_START;
        else               state_d = ST_IDLE;
      end
      ST_START: begin
        if (bps_tick) state_d = ST_DATA;
        else          state_d = ST_START;
      end
      ST_DATA: begin
        if (bps_tick && (bit_cnt_q == LAST_BIT)) begin
          if (par_mode_q != PAR_NONE) state_d = ST_PARITY;
          else                        state_d = ST_STOP1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bps_tick) state_d = ST_STOP1;
        else          state_d = ST_PARITY;
      end
      ST_STOP1, ST_STOP2: begin
        if (!bps_tick)          state_d = state_q;
        else if (!stop_wait_q)  state_d = ((state_q == ST_STOP1) && stop2_q) ? ST_STOP2 : state_q;
        else if (!fifo_empty_s) state_d = ST_DATA;
        else                    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    txd_d       = txd_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_mode_d  = par_mode_q;
    stop2_d     = stop2_q;
    par_bit_d   = par_bit_q;
    stop_wait_d = stop_wait_q;
    if (pop_s) begin
      shift_d    = fifo_rd_data_s;
      par_mode_d = par_mode_e'(parity_mode);
      stop2_d    = stop2;
      par_bit_d  = calc_parity(MAX_DATA_W'(fifo_rd_data_s), par_mode_e'(parity_mode));
      bit_cnt_d  = CNT_W'(0);
    end else begin
      shift_d = shift_q;
    end
    case (state_q)
      ST_IDLE: txd_d = 1'b1;
      ST_START: begin
        if (bps_tick) begin
          txd_d     = 1'b0;
          bit_cnt_d = CNT_W'(0);
        end else begin
          txd_d = txd_q;
        end
      end
      ST_DATA: begin
        if (bps_tick) begin
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          txd_d = txd_q;
        end
      end
      ST_PARITY: begin
        if (bps_tick) txd_d = par_bit_q;
        else          txd_d = txd_q;
      end
      ST_STOP1, ST_STOP2: begin
        if (!bps_tick) begin
          txd_d = txd_q;
        end else if (!stop_wait_q) begin
          txd_d       = 1'b1;
          stop_wait_d = (state_q == ST_STOP2) | ~stop2_q;
        end else begin
          stop_wait_d = 1'b0;
          txd_d       = fifo_empty_s;
        end
      end
      default: txd_d = 1'b1;
    endcase
  end

  assign TXD        = txd_q;
  assign busy       = busy_q;
  assign bps_en     = busy_q;
  assign overflow   = overflow_q;
  assign fifo_full  = fifo_full_s;
  assign fifo_empty = fifo_empty_s;
  assign fifo_level = fifo_level_s;

endmodule
